// File: rtl/button_press_classifier_if.sv
// Edge pulses from the debouncer into the classifier, plus the classified events out of it.
interface button_press_classifier_if;
    logic       button_just_went_active;
    logic       button_just_went_inactive;
    logic       short_press;
    logic       long_press;
    logic       double_press;
    logic       long_held;
    logic [7:0] event_count;

    modport master (
        output button_just_went_active,
        output button_just_went_inactive,
        input  short_press,
        input  long_press,
        input  double_press,
        input  long_held,
        input  event_count
    );

    modport slave (
        input  button_just_went_active,
        input  button_just_went_inactive,
        output short_press,
        output long_press,
        output double_press,
        output long_held,
        output event_count
    );
endinterface

// File: rtl/button_press_classifier.sv
// Classifies debounced press/release pulses into short, long and double press events.
//
// state     | meaning
// IDLE      | button released, no gesture in progress
// PRESS1    | first press held, timing toward long-press threshold
// GAP       | released after a short first press, waiting for a possible second press
// PRESS2    | second press held; release or threshold both classify as double
// LONG_HELD | long or double-long press still held, long_held asserted
module button_press_classifier #(
    parameter int LONG_PRESS_CLOCK_PERIODS       = 100,
    parameter int DOUBLE_PRESS_GAP_CLOCK_PERIODS = 50,
    parameter int COUNTER_WIDTH                  = 32
) (
    input logic clock,
    input logic reset,
    button_press_classifier_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        PRESS2,
        LONG_HELD
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] LONG_LAST = COUNTER_WIDTH'(LONG_PRESS_CLOCK_PERIODS - 1);
    localparam logic [COUNTER_WIDTH-1:0] GAP_LAST  = COUNTER_WIDTH'(DOUBLE_PRESS_GAP_CLOCK_PERIODS - 1);

    state_t                   state;
    logic [COUNTER_WIDTH-1:0] cnt;
    logic                     short_press_q;
    logic                     long_press_q;
    logic                     double_press_q;
    logic                     long_held_q;
    logic [7:0]               event_count_q;
    logic                     act;
    logic                     inact;

    // Coincident press and release edges are treated as a glitch and dropped.
    assign act   = bus.button_just_went_active & ~bus.button_just_went_inactive;
    assign inact = bus.button_just_went_inactive & ~bus.button_just_went_active;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            short_press_q  <= 1'b0;
            long_press_q   <= 1'b0;
            double_press_q <= 1'b0;
            long_held_q    <= 1'b0;
            event_count_q  <= 8'h00;
        end else begin
            short_press_q  <= 1'b0;
            long_press_q   <= 1'b0;
            double_press_q <= 1'b0;
            cnt            <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (act) begin
                        state <= PRESS1;
                        cnt   <= '0;
                    end
                end
                PRESS1: begin
                    if (inact) begin
                        state <= GAP;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state         <= LONG_HELD;
                        cnt           <= '0;
                        long_press_q  <= 1'b1;
                        long_held_q   <= 1'b1;
                        event_count_q <= event_count_q + 8'd1;
                    end
                end
                GAP: begin
                    // A press landing on the expiry cycle still counts as the second press.
                    if (act) begin
                        state <= PRESS2;
                        cnt   <= '0;
                    end else if (cnt == GAP_LAST) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        short_press_q <= 1'b1;
                        event_count_q <= event_count_q + 8'd1;
                    end
                end
                PRESS2: begin
                    if (inact) begin
                        state          <= IDLE;
                        cnt            <= '0;
                        double_press_q <= 1'b1;
                        event_count_q  <= event_count_q + 8'd1;
                    end else if (cnt == LONG_LAST) begin
                        state          <= LONG_HELD;
                        cnt            <= '0;
                        double_press_q <= 1'b1;
                        long_held_q    <= 1'b1;
                        event_count_q  <= event_count_q + 8'd1;
                    end
                end
                LONG_HELD: begin
                    if (inact) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        long_held_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    long_held_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.short_press  = short_press_q;
    assign bus.long_press   = long_press_q;
    assign bus.double_press = double_press_q;
    assign bus.long_held    = long_held_q;
    assign bus.event_count  = event_count_q;
endmodule

// File: tb/tb_button_press_classifier.sv
// Directed gesture bench for button_press_classifier with LONG=10, GAP=5.
module tb_button_press_classifier;
    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   edge_n;
    int   base;
    int   short_cnt, long_cnt, double_cnt;
    int   short_edge, long_edge, double_edge;
    int   held_rise, held_fall;
    int   multi_pulse;
    logic held_prev;

    button_press_classifier_if bus();

    button_press_classifier #(
        .LONG_PRESS_CLOCK_PERIODS      (10),
        .DOUBLE_PRESS_GAP_CLOCK_PERIODS(5),
        .COUNTER_WIDTH                 (32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) edge_n++;

    // Pulses are sampled at the falling edge; edge index is relative to the gesture start.
    always @(negedge clock) begin
        if (bus.short_press) begin
            if (short_cnt == 0) short_edge = edge_n - base;
            short_cnt++;
        end
        if (bus.long_press) begin
            if (long_cnt == 0) long_edge = edge_n - base;
            long_cnt++;
        end
        if (bus.double_press) begin
            if (double_cnt == 0) double_edge = edge_n - base;
            double_cnt++;
        end
        if (int'(bus.short_press) + int'(bus.long_press) + int'(bus.double_press) > 1)
            multi_pulse++;
        if (bus.long_held && !held_prev && held_rise < 0) held_rise = edge_n - base;
        if (!bus.long_held && held_prev && held_fall < 0) held_fall = edge_n - base;
        held_prev = bus.long_held;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drives one gesture; event indices are edges relative to the first loop edge (-1 = none).
    task automatic gesture(input int p0, input int r0, input int p1, input int r1,
                           input int rst_at, input int total, input logic both_at0);
        base        = edge_n + 1;
        short_cnt   = 0;
        long_cnt    = 0;
        double_cnt  = 0;
        short_edge  = -1;
        long_edge   = -1;
        double_edge = -1;
        held_rise   = -1;
        held_fall   = -1;
        multi_pulse = 0;
        for (int k = 0; k < total; k++) begin
            bus.button_just_went_active   = (k == p0) || (k == p1) || (both_at0 && k == 0);
            bus.button_just_went_inactive = (k == r0) || (k == r1) || (both_at0 && k == 0);
            reset = (k == rst_at) ? 1'b0 : 1'b1;
            @(posedge clock);
            #1;
        end
        bus.button_just_went_active   = 1'b0;
        bus.button_just_went_inactive = 1'b0;
        reset = 1'b1;
    endtask

    task automatic expect_pulses(input string tag, input int s_e, input int l_e, input int d_e,
                                 input logic [7:0] ec_exp);
        chk({tag, "_short_n"},  short_cnt,  (s_e >= 0) ? 1 : 0);
        chk({tag, "_short_at"}, short_edge, s_e);
        chk({tag, "_long_n"},   long_cnt,   (l_e >= 0) ? 1 : 0);
        chk({tag, "_long_at"},  long_edge,  l_e);
        chk({tag, "_dbl_n"},    double_cnt, (d_e >= 0) ? 1 : 0);
        chk({tag, "_dbl_at"},   double_edge, d_e);
        chk({tag, "_multi"},    multi_pulse, 0);
        chk({tag, "_count"},    int'(bus.event_count), int'(ec_exp));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        edge_n    = 0;
        base      = 0;
        held_prev = 1'b0;
        reset     = 1'b0;
        bus.button_just_went_active   = 1'b0;
        bus.button_just_went_inactive = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_short", int'(bus.short_press), 0);
        chk("rst_long",  int'(bus.long_press), 0);
        chk("rst_dbl",   int'(bus.double_press), 0);
        chk("rst_held",  int'(bus.long_held), 0);
        chk("rst_count", int'(bus.event_count), 0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // short press
        gesture(0, 3, -1, -1, -1, 15, 1'b0);
        expect_pulses("t1", 8, -1, -1, 8'd1);

        // long press held 20 cycles
        gesture(0, 20, -1, -1, -1, 30, 1'b0);
        expect_pulses("t2", -1, 10, -1, 8'd2);
        chk("t2_held_rise", held_rise, 10);
        chk("t2_held_fall", held_fall, 20);

        // double press
        gesture(0, 3, 6, 8, -1, 20, 1'b0);
        expect_pulses("t3", -1, -1, 8, 8'd3);

        // release exactly at the long threshold
        gesture(0, 10, -1, -1, -1, 20, 1'b0);
        expect_pulses("t4a", 15, -1, -1, 8'd4);
        chk("t4a_held", held_rise, -1);

        // second press exactly at gap expiry
        gesture(0, 3, 8, 10, -1, 20, 1'b0);
        expect_pulses("t4b", -1, -1, 10, 8'd5);

        // double press with long second hold
        gesture(0, 2, 4, 20, -1, 30, 1'b0);
        expect_pulses("t4c", -1, -1, 14, 8'd6);
        chk("t4c_held_rise", held_rise, 14);
        chk("t4c_held_fall", held_fall, 20);

        // reset mid-PRESS1
        gesture(0, -1, -1, -1, 5, 25, 1'b0);
        expect_pulses("t5a", -1, -1, -1, 8'd0);
        chk("t5a_held", int'(bus.long_held), 0);

        // reset mid-GAP
        gesture(0, 3, -1, -1, 5, 20, 1'b0);
        expect_pulses("t5b", -1, -1, -1, 8'd0);

        gesture(0, 2, -1, -1, -1, 12, 1'b0);
        expect_pulses("t5c", 7, -1, -1, 8'd1);

        // coincident edges in IDLE are ignored
        gesture(-1, -1, -1, -1, -1, 20, 1'b1);
        expect_pulses("t6b", -1, -1, -1, 8'd1);

        // wrap: 255 more short presses bring the count from 1 to 0
        for (int n = 0; n < 255; n++) begin
            gesture(0, 1, -1, -1, -1, 8, 1'b0);
            if (n == 253) chk("t6_count_255", int'(bus.event_count), 255);
        end
        chk("t6_wrap", int'(bus.event_count), 0);
        chk("t6_last_short", short_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
